// File: rtl/core_if_id.sv
// -----------------------------------------------------------------------------
// core_if_id: IF->ID pipeline register with a valid/ready handshake.
//
// Captures an (inst_addr, inst) pair for every accepted IF beat and presents the
// pairs to decode in acceptance order, with no loss and no duplication. A taken
// jump/branch (flush_in) kills every held entry and leaves a NOP bubble.
//
// Build option (macro IF_ID_SKID_EN):
//   defined   : two entries (main M + skid S), if_ready_out comes from a flop.
//   undefined : main entry only, if_ready_out = ~id_valid_out | id_ready_in.
//
// Ports:
//   clk              clock, all state on the rising edge
//   rst              synchronous active-high reset (has priority over flush_in)
//   if_inst_addr_in  instruction address from core_if
//   if_inst_in       instruction word from core_if
//   if_valid_in      IF beat valid
//   if_ready_out     this stage can accept a beat
//   flush_in         jump/branch taken: drop all held entries
//   id_inst_addr_out address to decode (holds last main address when invalid)
//   id_inst_out      instruction to decode (NOP_INST when invalid)
//   id_valid_out     decode beat valid
//   id_ready_in      decode accepts the beat
// -----------------------------------------------------------------------------
module core_if_id #(
  parameter logic [31:0] NOP_INST   = 32'h0000_0013,
  parameter logic [31:0] RESET_ADDR = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] if_inst_addr_in,
  input  logic [31:0] if_inst_in,
  input  logic        if_valid_in,
  output logic        if_ready_out,
  input  logic        flush_in,
  output logic [31:0] id_inst_addr_out,
  output logic [31:0] id_inst_out,
  output logic        id_valid_out,
  input  logic        id_ready_in
);

  logic        accept;
  logic        consume;
  logic        id_valid_q, id_valid_d;
  logic [31:0] m_addr_q, m_addr_d;
  logic [31:0] m_inst_q, m_inst_d;

`ifdef IF_ID_SKID_EN

  typedef enum logic [1:0] {StEmpty, StOne, StFull} state_e;

  state_e      state_q, state_d;
  logic [31:0] s_addr_q, s_addr_d;
  logic [31:0] s_inst_q, s_inst_d;
  logic        if_ready_q, if_ready_d;

  assign accept  = if_valid_in & if_ready_q;
  assign consume = id_valid_q & id_ready_in;

  always_comb begin
    state_d  = state_q;
    m_addr_d = m_addr_q;
    m_inst_d = m_inst_q;
    s_addr_d = s_addr_q;
    s_inst_d = s_inst_q;

    if (flush_in) begin
      // Any beat accepted this cycle is dropped; M keeps its old address.
      state_d  = StEmpty;
      s_addr_d = '0;
      s_inst_d = '0;
    end else begin
      unique case (state_q)
        StEmpty: begin
          if (accept) begin
            state_d  = StOne;
            m_addr_d = if_inst_addr_in;
            m_inst_d = if_inst_in;
          end
        end
        StOne: begin
          if (accept && consume) begin
            m_addr_d = if_inst_addr_in;
            m_inst_d = if_inst_in;
          end else if (accept) begin
            state_d  = StFull;
            s_addr_d = if_inst_addr_in;
            s_inst_d = if_inst_in;
          end else if (consume) begin
            state_d = StEmpty;
          end
        end
        StFull: begin
          // if_ready_q is low here, so no accept can coincide with the drain.
          if (consume) begin
            state_d  = StOne;
            m_addr_d = s_addr_q;
            m_inst_d = s_inst_q;
          end
        end
        default: state_d = StEmpty;
      endcase
    end

    id_valid_d = (state_d != StEmpty);
    if_ready_d = (state_d != StFull);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= StEmpty;
      m_addr_q   <= RESET_ADDR;
      m_inst_q   <= NOP_INST;
      s_addr_q   <= '0;
      s_inst_q   <= '0;
      id_valid_q <= 1'b0;
      if_ready_q <= 1'b1;
    end else begin
      state_q    <= state_d;
      m_addr_q   <= m_addr_d;
      m_inst_q   <= m_inst_d;
      s_addr_q   <= s_addr_d;
      s_inst_q   <= s_inst_d;
      id_valid_q <= id_valid_d;
      if_ready_q <= if_ready_d;
    end
  end

  assign if_ready_out = if_ready_q;

`else

  // Single entry: a new beat may enter while the held one leaves this cycle.
  assign if_ready_out = ~id_valid_q | id_ready_in;
  assign accept       = if_valid_in & if_ready_out;
  assign consume      = id_valid_q & id_ready_in;

  always_comb begin
    id_valid_d = id_valid_q;
    m_addr_d   = m_addr_q;
    m_inst_d   = m_inst_q;

    if (flush_in) begin
      id_valid_d = 1'b0;
    end else if (accept) begin
      id_valid_d = 1'b1;
      m_addr_d   = if_inst_addr_in;
      m_inst_d   = if_inst_in;
    end else if (consume) begin
      id_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      m_addr_q   <= RESET_ADDR;
      m_inst_q   <= NOP_INST;
      id_valid_q <= 1'b0;
    end else begin
      m_addr_q   <= m_addr_d;
      m_inst_q   <= m_inst_d;
      id_valid_q <= id_valid_d;
    end
  end

`endif

  assign id_valid_out     = id_valid_q;
  assign id_inst_out      = id_valid_q ? m_inst_q : NOP_INST;
  assign id_inst_addr_out = m_addr_q;

endmodule

// File: tb/tb_core_if_id.sv
module tb_core_if_id;

  localparam logic [31:0] NOP        = 32'h0000_0013;
  localparam logic [31:0] RESET_ADDR = 32'h0000_0000;
`ifdef IF_ID_SKID_EN
  localparam bit Skid = 1'b1;
`else
  localparam bit Skid = 1'b0;
`endif

  localparam logic [31:0] InstA = 32'h00a0_0093;
  localparam logic [31:0] InstB = 32'h00b0_0113;
  localparam logic [31:0] InstC = 32'h00c0_0193;
  localparam logic [31:0] InstD = 32'h00d0_0213;
  localparam logic [31:0] InstE = 32'h00e0_0293;
  localparam logic [31:0] InstX = 32'h0ff0_0313;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] if_inst_addr_in;
  logic [31:0] if_inst_in;
  logic        if_valid_in;
  logic        if_ready_out;
  logic        flush_in;
  logic [31:0] id_inst_addr_out;
  logic [31:0] id_inst_out;
  logic        id_valid_out;
  logic        id_ready_in;

  always #5 clk = ~clk;

  core_if_id #(
    .NOP_INST  (NOP),
    .RESET_ADDR(RESET_ADDR)
  ) dut (
    .clk             (clk),
    .rst             (rst),
    .if_inst_addr_in (if_inst_addr_in),
    .if_inst_in      (if_inst_in),
    .if_valid_in     (if_valid_in),
    .if_ready_out    (if_ready_out),
    .flush_in        (flush_in),
    .id_inst_addr_out(id_inst_addr_out),
    .id_inst_out     (id_inst_out),
    .id_valid_out    (id_valid_out),
    .id_ready_in     (id_ready_in)
  );

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model: an in-order queue of {addr, inst} beats held by the stage.
  logic [63:0] q[$];
  logic [31:0] last_addr;
  bit          live = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic bit model_ready();
    if (Skid) return q.size() < 2;
    return (q.size() == 0) || (id_ready_in == 1'b1);
  endfunction

  // One clock: drive inputs, check ready before the edge, advance the model,
  // check the registered outputs just after the edge.
  task automatic cyc(input logic r, input logic f, input logic v, input logic [31:0] a,
                     input logic [31:0] i, input logic ir);
    bit acc;
    bit con;
    rst             = r;
    flush_in        = f;
    if_valid_in     = v;
    if_inst_addr_in = a;
    if_inst_in      = i;
    id_ready_in     = ir;
    #1;
    if (live) chk("if_ready", {31'b0, if_ready_out}, {31'b0, model_ready()});
    acc = live && v && model_ready();
    con = (q.size() > 0) && ir;
    @(posedge clk);
    if (r) begin
      q.delete();
      last_addr = RESET_ADDR;
      live      = 1'b1;
    end else if (f) begin
      q.delete();
    end else begin
      if (con) void'(q.pop_front());
      if (acc) q.push_back({a, i});
      if (q.size() > 0) last_addr = q[0][63:32];
    end
    #1;
    if (live) begin
      chk("id_valid", {31'b0, id_valid_out}, {31'b0, q.size() > 0});
      chk("id_inst", id_inst_out, (q.size() > 0) ? q[0][31:0] : NOP);
      chk("id_addr", id_inst_addr_out, last_addr);
    end
  endtask

  typedef struct {
    logic        r, f, v;
    logic [31:0] a, i;
    logic        ir;
    logic        ev;
    logic [31:0] ei, ea;
  } vec_t;

  vec_t tbl[11];

  initial begin
    // Directed vectors with expectations written straight from the rules.
    tbl[0]  = '{1, 0, 1, 32'h100, 32'hdead_beef, 1, 0, NOP, RESET_ADDR};
    tbl[1]  = '{1, 0, 1, 32'h100, 32'hdead_beef, 1, 0, NOP, RESET_ADDR};
    tbl[2]  = '{0, 0, 1, 32'h0,   InstA, 1, 1, InstA, 32'h0};
    tbl[3]  = '{0, 0, 1, 32'h4,   InstB, 1, 1, InstB, 32'h4};
    tbl[4]  = '{0, 0, 1, 32'h8,   InstC, 1, 1, InstC, 32'h8};
    tbl[5]  = '{0, 0, 0, 32'h0,   32'h0, 1, 0, NOP,   32'h8};
    tbl[6]  = '{0, 0, 1, 32'h10,  InstX, 0, 1, InstX, 32'h10};
    tbl[7]  = '{0, 1, 1, 32'h40,  InstE, 1, 0, NOP,   32'h10};
    tbl[8]  = '{0, 0, 0, 32'h0,   32'h0, 1, 0, NOP,   32'h10};
    tbl[9]  = '{1, 1, 1, 32'h44,  InstE, 1, 0, NOP,   RESET_ADDR};
    tbl[10] = '{0, 0, 1, 32'h20,  InstD, 1, 1, InstD, 32'h20};

    for (int k = 0; k < 11; k++) begin
      cyc(tbl[k].r, tbl[k].f, tbl[k].v, tbl[k].a, tbl[k].i, tbl[k].ir);
      chk($sformatf("tbl%0d_valid", k), {31'b0, id_valid_out}, {31'b0, tbl[k].ev});
      chk($sformatf("tbl%0d_inst", k), id_inst_out, tbl[k].ei);
      chk($sformatf("tbl%0d_addr", k), id_inst_addr_out, tbl[k].ea);
    end
    chk("reset_ready", {31'b0, if_ready_out}, 32'd1);
    cyc(0, 0, 0, 0, 0, 1);
    chk("drain_valid", {31'b0, id_valid_out}, 32'd0);

`ifdef IF_ID_SKID_EN
    // Back-pressure fills both entries, then drains A, B, C in order.
    cyc(0, 0, 1, 32'h0, InstA, 0);
    cyc(0, 0, 1, 32'h4, InstB, 0);
    chk("full_ready", {31'b0, if_ready_out}, 32'd0);
    chk("full_head", id_inst_out, InstA);
    cyc(0, 0, 1, 32'h8, InstC, 0);
    chk("full_hold", id_inst_out, InstA);
    cyc(0, 0, 1, 32'h8, InstC, 1);
    chk("drain_b", id_inst_out, InstB);
    cyc(0, 0, 1, 32'h8, InstC, 1);
    chk("drain_c", id_inst_out, InstC);
    cyc(0, 0, 0, 32'h0, 32'h0, 1);
    chk("drain_empty", {31'b0, id_valid_out}, 32'd0);
    // Flush while full.
    cyc(0, 0, 1, 32'h0, InstA, 0);
    cyc(0, 0, 1, 32'h4, InstB, 0);
    cyc(0, 1, 0, 32'h0, 32'h0, 0);
    chk("flush_valid", {31'b0, id_valid_out}, 32'd0);
    chk("flush_nop", id_inst_out, NOP);
    chk("flush_ready", {31'b0, if_ready_out}, 32'd1);
    cyc(0, 0, 1, 32'h20, InstD, 1);
    chk("after_flush_d", id_inst_out, InstD);
    cyc(0, 0, 0, 32'h0, 32'h0, 1);
`else
    // Ready follows id_ready_in combinationally while M is valid.
    cyc(0, 0, 1, 32'h0, InstA, 0);
    chk("m_valid", id_inst_out, InstA);
    id_ready_in = 1'b0;
    #1;
    chk("comb_ready_lo", {31'b0, if_ready_out}, 32'd0);
    id_ready_in = 1'b1;
    #1;
    chk("comb_ready_hi", {31'b0, if_ready_out}, 32'd1);
    cyc(0, 0, 1, 32'h4, InstB, 1);
    chk("stream_b", id_inst_out, InstB);
    cyc(0, 0, 1, 32'h8, InstC, 1);
    chk("stream_c", id_inst_out, InstC);
    cyc(0, 0, 0, 32'h0, 32'h0, 1);
    chk("stream_empty", {31'b0, id_valid_out}, 32'd0);
`endif

    // Randomized traffic against the queue model.
    for (int k = 0; k < 600; k++) begin
      cyc($urandom_range(0, 63) == 0, $urandom_range(0, 15) == 0, $urandom_range(0, 3) != 0,
          $urandom & 32'hffff_fffc, $urandom, $urandom_range(0, 3) != 0);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
